// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Provides the state encoding (also exported on dbg_state) and the counter-width helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pll_seq_state_e;

  // Bits needed to hold values 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. No reset: the flops
// flush within two cycles, and the sequencer is held in reset meanwhile.
// Ports:
//   clk  in  destination clock
//   d_i  in  asynchronous input
//   q_o  out synchronized output
module sync_2ff (
  input  logic clk,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    ff1_q <= d_i;
    ff2_q <= ff1_q;
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and system reset release sequencer, clocked by the raw board
// oscillator. Holds the PLL in reset, qualifies the synchronized lock signal,
// releases sys_reset after a stable-lock plus hold interval and re-asserts it
// on any loss of lock.
// Optional feature macro: LOCK_TIMEOUT_EN (WAIT_LOCK timeout, PLL retries, FAULT).
// Ports:
//   clk             in   12 MHz oscillator
//   reset           in   synchronous active-high reset
//   pll_locked      in   PLL LOCK, asynchronous
//   pll_resetb      out  PLL RESETB, active-low
//   sys_reset       out  system reset request, active-high
//   ready           out  high only in RUN
//   fault           out  lock never achieved after all retries
//   lock_loss_count out  saturating count of lock losses in RUN
//   dbg_state       out  current state encoding
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 12,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 120000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  output logic             pll_resetb,
  output logic             sys_reset,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [2:0]       dbg_state
);

  // One phase counter is shared by PLL_RST, STABLE and HOLD.
  localparam int unsigned MAX_PH = (PLL_RST_CYCLES > STABLE_CYCLES)
                                   ? ((PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES)
                                   : ((STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES);
  localparam int unsigned CW = cnt_w(MAX_PH);

  logic lock_s;

  pll_seq_state_e    state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic              pll_resetb_q, pll_resetb_d;
  logic              sys_reset_q, sys_reset_d;
  logic              ready_q, ready_d;

`ifdef LOCK_TIMEOUT_EN
  localparam int unsigned TW = cnt_w(TIMEOUT_CYCLES);
  localparam int unsigned RW = cnt_w(MAX_RETRIES);
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fault_q, fault_d;
`else
  // Timeout parameters are consumed only when the timeout feature is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, MAX_RETRIES};
`endif

  sync_2ff u_lock_sync (
    .clk (clk),
    .d_i (pll_locked),
    .q_o (lock_s)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
      timer_q      <= '0;
      retry_q      <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
`ifdef LOCK_TIMEOUT_EN
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      fault_q      <= fault_d;
`endif
    end
  end

  // Next state, counters, and outputs decoded from the next state so they
  // change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
`ifdef LOCK_TIMEOUT_EN
    timer_d = '0;  // cleared outside WAIT_LOCK, so every entry starts at 0
    retry_d = retry_q;
`endif

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = STABLE;
        end
`ifdef LOCK_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d = retry_q + RW'(1);
            state_d = PLL_RST;
          end else begin
            state_d = FAULT;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        // Lock loss takes priority over the hold count expiring.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
`ifdef LOCK_TIMEOUT_EN
          retry_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != '1) begin
            loss_d = loss_q + CNT_W'(1);
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    pll_resetb_d = (state_d != PLL_RST) && (state_d != FAULT);
    sys_reset_d  = (state_d != RUN);
    ready_d      = (state_d == RUN);
`ifdef LOCK_TIMEOUT_EN
    fault_d      = (state_d == FAULT);
`endif
  end

  assign pll_resetb      = pll_resetb_q;
  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;
  assign dbg_state       = 3'(state_q);
`ifdef LOCK_TIMEOUT_EN
  assign fault           = fault_q;
`else
  assign fault           = 1'b0;
`endif

endmodule
